// File: rtl/spi_operand_slave.sv
// SPI slave that collects N_OPS operand words per frame, publishes them in one
// pulse, then shifts a DATA_W-bit result back out on MISO.
`timescale 1ns/1ps
module spi_operand_slave #(
    parameter int DATA_W      = 8,
    parameter int N_OPS       = 2,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_cs_n,
    input  logic                      spi_sclk,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    output logic [N_OPS*DATA_W-1:0]   ops_data,
    output logic                      ops_valid,
    input  logic [DATA_W-1:0]         tx_data,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int BC_W = $clog2(DATA_W);
    localparam int WC_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(DATA_W - 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(N_OPS - 1);
    localparam logic IDLE_LVL = (CPOL != 0);

    typedef enum logic [1:0] {IDLE, RX, TX, DONE} state_t;

    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic [SYNC_STAGES-1:0] vld_reg;
    logic                   cs_d_reg;
    logic                   sclk_d_reg;

    state_t                 state_reg;
    logic [BC_W-1:0]        bit_cnt_reg;
    logic [WC_W-1:0]        word_cnt_reg;
    logic [DATA_W-2:0]      rx_shift_reg;
    logic [DATA_W-1:0]      tx_shift_reg;
    logic [DATA_W-1:0]      slot_reg [N_OPS];
    logic                   overrun_reg;
    logic                   latch_pend_reg;
    logic                   armed_reg;

    logic cs_s, sclk_s, mosi_s;
    logic cs_fall, cs_rise;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge;
    logic [DATA_W-1:0]       rx_word;
    logic [N_OPS*DATA_W-1:0] ops_next;

    assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

    assign cs_fall    = cs_d_reg & ~cs_s;
    assign cs_rise    = ~cs_d_reg & cs_s;
    assign sclk_rise  = sclk_s & ~sclk_d_reg;
    assign sclk_fall  = ~sclk_s & sclk_d_reg;
    assign lead_edge  = IDLE_LVL ? sclk_fall : sclk_rise;
    assign trail_edge = IDLE_LVL ? sclk_rise : sclk_fall;
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

    assign rx_word = {rx_shift_reg, mosi_s};

    // The slot being completed this clk takes the freshly assembled word.
    generate
        for (genvar gi = 0; gi < N_OPS; gi++) begin : g_slot
            assign ops_next[gi*DATA_W +: DATA_W] =
                (word_cnt_reg == WC_W'(gi)) ? rx_word : slot_reg[gi];
        end
    endgenerate

    // vld_reg marks when the synchroniser no longer holds reset-injected values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_reg   <= '1;
            sclk_sync_reg <= {SYNC_STAGES{IDLE_LVL}};
            mosi_sync_reg <= '0;
            vld_reg       <= '0;
            cs_d_reg      <= 1'b1;
            sclk_d_reg    <= IDLE_LVL;
        end else begin
            cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
            vld_reg       <= {vld_reg[SYNC_STAGES-2:0], 1'b1};
            cs_d_reg      <= cs_s;
            sclk_d_reg    <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            word_cnt_reg   <= '0;
            rx_shift_reg   <= '0;
            tx_shift_reg   <= '0;
            overrun_reg    <= 1'b0;
            latch_pend_reg <= 1'b0;
            armed_reg      <= 1'b0;
            spi_miso       <= 1'b0;
            ops_data       <= '0;
            ops_valid      <= 1'b0;
            frame_err      <= 1'b0;
            busy           <= 1'b0;
            for (int i = 0; i < N_OPS; i++) slot_reg[i] <= '0;
        end else begin
            ops_valid <= 1'b0;
            frame_err <= 1'b0;
            busy      <= ~cs_s;
            // A frame already running when reset lifted must not be joined.
            armed_reg <= armed_reg | (vld_reg[SYNC_STAGES-1] & cs_s);

            if (cs_rise) begin
                state_reg      <= IDLE;
                spi_miso       <= 1'b0;
                frame_err      <= (state_reg == RX) || (state_reg == TX) || overrun_reg;
                overrun_reg    <= 1'b0;
                latch_pend_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (cs_fall && armed_reg) begin
                            state_reg    <= RX;
                            bit_cnt_reg  <= '0;
                            word_cnt_reg <= '0;
                            spi_miso     <= 1'b0;
                        end
                    end
                    RX: begin
                        if (sample_edge) begin
                            rx_shift_reg <= rx_word[DATA_W-2:0];
                            if (bit_cnt_reg == BC_MAX) begin
                                bit_cnt_reg            <= '0;
                                slot_reg[word_cnt_reg] <= rx_word;
                                if (word_cnt_reg == WC_MAX) begin
                                    ops_data       <= ops_next;
                                    ops_valid      <= 1'b1;
                                    latch_pend_reg <= 1'b1;
                                    state_reg      <= TX;
                                end else begin
                                    word_cnt_reg <= word_cnt_reg + 1'b1;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                    TX: begin
                        if (latch_pend_reg) begin
                            latch_pend_reg <= 1'b0;
                            if (CPHA == 0) begin
                                spi_miso     <= tx_data[DATA_W-1];
                                tx_shift_reg <= {tx_data[DATA_W-2:0], 1'b0};
                            end else begin
                                tx_shift_reg <= tx_data;
                            end
                        end else begin
                            // In mode CPHA=0 the trailing edge of the last operand bit lands here; skip it.
                            if (shift_edge && ((CPHA != 0) || (bit_cnt_reg != '0))) begin
                                spi_miso     <= tx_shift_reg[DATA_W-1];
                                tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
                            end
                            if (sample_edge) begin
                                if (bit_cnt_reg == BC_MAX) begin
                                    state_reg   <= DONE;
                                    spi_miso    <= 1'b0;
                                    bit_cnt_reg <= '0;
                                end else begin
                                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                                end
                            end
                        end
                    end
                    DONE: begin
                        if (sample_edge) overrun_reg <= 1'b1;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_operand_slave.sv
// Randomised scoreboard bench for spi_operand_slave across three configurations:
// 8x2 mode 0, 8x2 mode 3, 16x3 mode 1.
`timescale 1ns/1ps
module tb_spi_operand_slave;

    localparam int HALF = 6;

    typedef struct {
        int          d;
        logic [63:0] v;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cs_n_a [3];
    logic        sclk_a [3];
    logic        mosi_a [3];
    logic        miso0, miso1, miso2;
    logic        ov0, ov1, ov2;
    logic        fe0, fe1, fe2;
    logic        busy0, busy1, busy2;
    logic [15:0] ops0, ops1;
    logic [47:0] ops2;
    logic [7:0]  tx0, tx1;
    logic [15:0] tx2;

    int          n_cmp = 0;
    int          n_bad = 0;
    ev_t         ops_q [$];
    int          err_q [$];
    logic [63:0] model_ops [3];

    spi_operand_slave #(.DATA_W(8), .N_OPS(2), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .spi_cs_n(cs_n_a[0]), .spi_sclk(sclk_a[0]), .spi_mosi(mosi_a[0]),
        .spi_miso(miso0), .ops_data(ops0), .ops_valid(ov0), .tx_data(tx0),
        .frame_err(fe0), .busy(busy0));

    spi_operand_slave #(.DATA_W(8), .N_OPS(2), .CPOL(1), .CPHA(1), .SYNC_STAGES(3)) dut1 (
        .clk(clk), .rst(rst), .spi_cs_n(cs_n_a[1]), .spi_sclk(sclk_a[1]), .spi_mosi(mosi_a[1]),
        .spi_miso(miso1), .ops_data(ops1), .ops_valid(ov1), .tx_data(tx1),
        .frame_err(fe1), .busy(busy1));

    spi_operand_slave #(.DATA_W(16), .N_OPS(3), .CPOL(0), .CPHA(1), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .spi_cs_n(cs_n_a[2]), .spi_sclk(sclk_a[2]), .spi_mosi(mosi_a[2]),
        .spi_miso(miso2), .ops_data(ops2), .ops_valid(ov2), .tx_data(tx2),
        .frame_err(fe2), .busy(busy2));

    function automatic int dw_of(int d);   return (d == 2) ? 16 : 8; endfunction
    function automatic int nops_of(int d); return (d == 2) ? 3 : 2;  endfunction
    function automatic logic pol_of(int d); return (d == 1); endfunction
    function automatic logic pha_of(int d); return (d == 1) || (d == 2); endfunction

    function automatic logic get_miso(int d);
        case (d) 0: return miso0; 1: return miso1; default: return miso2; endcase
    endfunction
    function automatic logic get_busy(int d);
        case (d) 0: return busy0; 1: return busy1; default: return busy2; endcase
    endfunction
    function automatic logic get_ov(int d);
        case (d) 0: return ov0; 1: return ov1; default: return ov2; endcase
    endfunction
    function automatic logic get_fe(int d);
        case (d) 0: return fe0; 1: return fe1; default: return fe2; endcase
    endfunction
    function automatic logic [63:0] get_ops(int d);
        case (d) 0: return 64'(ops0); 1: return 64'(ops1); default: return 64'(ops2); endcase
    endfunction

    task automatic set_tx(input int d, input logic [15:0] w);
        case (d)
            0: tx0 = w[7:0];
            1: tx1 = w[7:0];
            default: tx2 = w;
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bit i of the vector is the i-th bit on the wire; each word goes MSB first.
    function automatic logic [127:0] words_to_vec(input int dw, input logic [15:0] w0,
                                                  input logic [15:0] w1, input logic [15:0] w2,
                                                  input logic [15:0] w3);
        logic [127:0] v;
        logic [15:0]  w [4];
        v = '0;
        w = '{w0, w1, w2, w3};
        for (int j = 0; j < 4; j++)
            for (int b = 0; b < dw; b++)
                v[j*dw + b] = w[j][dw-1-b];
        return v;
    endfunction

    task automatic send_bits(input int d, input logic [127:0] mvec, input int first,
                             input int cnt, inout logic [127:0] cap);
        logic pol;
        pol = pol_of(d);
        for (int k = first; k < first + cnt; k++) begin
            if (!pha_of(d)) begin
                mosi_a[d] = mvec[k];
                tick(HALF);
                cap[k]    = get_miso(d);
                sclk_a[d] = ~pol;
                tick(HALF);
                sclk_a[d] = pol;
            end else begin
                sclk_a[d] = ~pol;
                mosi_a[d] = mvec[k];
                tick(HALF);
                cap[k]    = get_miso(d);
                sclk_a[d] = pol;
                tick(HALF);
            end
        end
    endtask

    task automatic cs_low(input int d);
        cs_n_a[d] = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high(input int d);
        tick(HALF);
        cs_n_a[d] = 1'b1;
        tick(8);
    endtask

    // Reference: a frame of exactly (N+1)*DW bits is clean; at least N*DW bits publishes
    // the operands; the response occupies the word after the operands.
    task automatic run_frame(input int d, input logic [127:0] mvec, input int nbits,
                             input logic [15:0] txw);
        int           dw, n;
        logic [63:0]  ops_exp;
        logic [127:0] emiso, cap;
        ev_t          e;
        dw = dw_of(d);
        n  = nops_of(d);
        ops_exp = '0;
        emiso   = '0;
        cap     = '0;
        set_tx(d, txw);
        if (nbits >= n*dw) begin
            for (int j = 0; j < n; j++)
                for (int b = 0; b < dw; b++)
                    ops_exp[j*dw + (dw-1-b)] = mvec[j*dw + b];
            e.d = d;
            e.v = ops_exp;
            ops_q.push_back(e);
            model_ops[d] = ops_exp;
            for (int t = 0; t < dw; t++)
                if (n*dw + t < nbits) emiso[n*dw + t] = txw[dw-1-t];
        end
        if (nbits != (n+1)*dw) err_q.push_back(d);

        cs_low(d);
        check($sformatf("busy_high_d%0d", d), 64'(get_busy(d)), 64'd1);
        send_bits(d, mvec, 0, nbits, cap);
        cs_high(d);
        check($sformatf("busy_low_d%0d", d), 64'(get_busy(d)), 64'd0);
        check($sformatf("ops_hold_d%0d", d), get_ops(d), model_ops[d]);
        check($sformatf("miso_stream_d%0d", d), cap[63:0], emiso[63:0]);
        check($sformatf("miso_idle_d%0d", d), 64'(get_miso(d)), 64'd0);
        $display("frame dut%0d bits=%0d tx=%h ops=%h miso_bits=%h", d, nbits, txw,
                 get_ops(d), cap[63:0]);
    endtask

    task automatic mon_ops(input int d, input logic v, input logic [63:0] act);
        ev_t e;
        if (v) begin
            n_cmp++;
            if (ops_q.size() == 0) begin
                n_bad++;
                $display("FAIL ops_valid_d%0d: unexpected pulse, ops=%h, none expected", d, act);
            end else begin
                e = ops_q.pop_front();
                if (e.d != d || e.v !== act) begin
                    n_bad++;
                    $display("FAIL ops_valid_d%0d: got dut%0d ops=%h expected dut%0d ops=%h",
                             d, d, act, e.d, e.v);
                end
            end
        end
    endtask

    task automatic mon_err(input int d, input logic v);
        int ed;
        if (v) begin
            n_cmp++;
            if (err_q.size() == 0) begin
                n_bad++;
                $display("FAIL frame_err_d%0d: unexpected pulse, none expected", d);
            end else begin
                ed = err_q.pop_front();
                if (ed != d) begin
                    n_bad++;
                    $display("FAIL frame_err_d%0d: pulse from dut%0d, expected dut%0d", d, d, ed);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon_ops(0, ov0, 64'(ops0));
        mon_ops(1, ov1, 64'(ops1));
        mon_ops(2, ov2, 64'(ops2));
        mon_err(0, fe0);
        mon_err(1, fe1);
        mon_err(2, fe2);
    end

    initial begin
        logic [127:0] mv, cap;
        int           d, n, dw, kind, nbits;

        for (int i = 0; i < 3; i++) begin
            cs_n_a[i]    = 1'b1;
            sclk_a[i]    = pol_of(i);
            mosi_a[i]    = 1'b0;
            model_ops[i] = '0;
        end
        tx0 = '0; tx1 = '0; tx2 = '0;
        rst = 1'b1;
        tick(5);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ops_d%0d", i),  get_ops(i), 64'd0);
            check($sformatf("rst_valid_d%0d", i), 64'(get_ov(i)), 64'd0);
            check($sformatf("rst_err_d%0d", i),  64'(get_fe(i)), 64'd0);
            check($sformatf("rst_busy_d%0d", i), 64'(get_busy(i)), 64'd0);
            check($sformatf("rst_miso_d%0d", i), 64'(get_miso(i)), 64'd0);
        end
        rst = 1'b0;
        tick(10);

        run_frame(0, words_to_vec(8, 16'h12, 16'h34, 16'h00, 16'h00), 24, 16'h46);
        run_frame(1, words_to_vec(8, 16'hA5, 16'h0F, 16'h00, 16'h00), 24, 16'hC3);
        run_frame(2, words_to_vec(16, 16'h1111, 16'h2222, 16'h3333, 16'h0000), 64, 16'hBEEF);
        run_frame(0, words_to_vec(8, 16'h77, 16'h99, 16'h00, 16'h00), 11, 16'h5A);
        run_frame(0, words_to_vec(8, 16'h3C, 16'hE1, 16'hFF, 16'h00), 32, 16'h81);

        for (int it = 0; it < 16; it++) begin
            d    = $urandom_range(0, 2);
            n    = nops_of(d);
            dw   = dw_of(d);
            kind = $urandom_range(0, 3);
            case (kind)
                2:       nbits = $urandom_range(1, (n+1)*dw - 1);
                3:       nbits = (n+1)*dw + $urandom_range(1, dw);
                default: nbits = (n+1)*dw;
            endcase
            mv = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_frame(d, mv, nbits, 16'($urandom()));
        end

        // Reset in the middle of a frame: outputs clear and the rest of that frame is ignored.
        mv  = words_to_vec(8, 16'hD2, 16'h4B, 16'h00, 16'h00);
        cap = '0;
        set_tx(0, 16'h6E);
        cs_low(0);
        send_bits(0, mv, 0, 8, cap);
        rst = 1'b1;
        tick(3);
        check("midrst_ops", get_ops(0), 64'd0);
        check("midrst_valid", 64'(ov0), 64'd0);
        check("midrst_err", 64'(fe0), 64'd0);
        check("midrst_busy", 64'(busy0), 64'd0);
        check("midrst_miso", 64'(miso0), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) model_ops[i] = '0;
        send_bits(0, mv, 8, 16, cap);
        cs_high(0);
        check("midrst_ignored_ops", get_ops(0), 64'd0);
        run_frame(0, words_to_vec(8, 16'h5E, 16'hA1, 16'h00, 16'h00), 24, 16'h2D);

        tick(20);
        check("pending_ops_events", 64'(ops_q.size()), 64'd0);
        check("pending_err_events", 64'(err_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
